// File: rtl/cbrt_pkg.sv
// Shared types and default constants for the cube-root arbiter slice.
package cbrt_pkg;

  localparam int CBRT_W_X         = 8;
  localparam int CBRT_W_R         = 3;
  localparam int CBRT_ACK_TIMEOUT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_RESP
  } cbrt_arb_state_t;

endpackage

// File: rtl/cbrt_arbiter_if.sv
// Requester-side request/response bus of the cube-root arbiter.
// master = requesters, slave = arbiter.
interface cbrt_arbiter_if
  import cbrt_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W_X   = CBRT_W_X,
  parameter int W_R   = CBRT_W_R
);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*W_X-1:0] req_x;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ-1:0]     rsp_valid;
  logic [W_R-1:0]       rsp_result;
  logic                 rsp_err;
  logic [N_REQ-1:0]     rsp_ready;

  modport master (
    output req_valid, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );

endinterface

// File: rtl/cbrt_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit strictly
// after 'last', wrapping, wins; 'last' itself has the lowest priority.
module rr_pick
  import cbrt_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  // Scan from lowest to highest priority so the nearest candidate is written last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = |req;
    cand = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % N_REQ;
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cbrt_arbiter.sv
// Shares one cbrt unit among N_REQ requesters: round-robin grant, start/busy
// sequencing with an acknowledge timeout, and routing of the result back.
module cbrt_arbiter
  import cbrt_pkg::*;
#(
  parameter int  N_REQ = 4,
  parameter int  W_X   = CBRT_W_X,
  parameter int  W_R   = CBRT_W_R,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  cbrt_arbiter_if.slave    bus,
  output logic             cu_start,
  output logic [W_X-1:0]   cu_x,
  input  logic             cu_busy,
  input  logic [W_R-1:0]   cu_result,
  output logic [ID_W-1:0]  grant_id,
  output logic             active,
  output logic [15:0]      done_count
);

  localparam int ACK_W = $clog2(CBRT_ACK_TIMEOUT + 1);

  cbrt_arb_state_t state, state_nxt;

  logic [W_X-1:0]   x_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  last_q;
  logic [W_R-1:0]   res_q;
  logic             err_q;
  logic [ACK_W-1:0] ack_cnt;

  logic [N_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             ack_timeout;
  logic             rsp_take;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req  (bus.req_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Third consecutive low busy sample in WAIT_ACK gives up on the unit.
  assign ack_timeout = (ack_cnt == ACK_W'(CBRT_ACK_TIMEOUT - 1));
  assign rsp_take    = bus.rsp_ready[id_q];
  assign cu_x        = x_q;
  assign grant_id    = id_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (pick_any) state_nxt = ST_LAUNCH;
      ST_LAUNCH:    state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (cu_busy) state_nxt = ST_WAIT_DONE;
                    else if (ack_timeout) state_nxt = ST_RESP;
      ST_WAIT_DONE: if (!cu_busy) state_nxt = ST_RESP;
      ST_RESP:      if (rsp_take) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state; response fields are zero outside RESP.
  always_comb begin
    bus.req_ready       = (state == ST_IDLE) ? pick_gnt : '0;
    bus.rsp_valid       = '0;
    bus.rsp_valid[id_q] = (state == ST_RESP);
    bus.rsp_result      = (state == ST_RESP) ? res_q : '0;
    bus.rsp_err         = (state == ST_RESP) && err_q;
    cu_start            = (state == ST_LAUNCH);
    active              = (state != ST_IDLE);
  end

  // Operand capture at grant and round-robin pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      id_q   <= '0;
      last_q <= ID_W'(N_REQ - 1);
    end else if (state == ST_IDLE && pick_any) begin
      x_q    <= bus.req_x[pick_idx*W_X +: W_X];
      id_q   <= pick_idx;
      last_q <= pick_idx;
    end
  end

  // Acknowledge timeout counter, result and error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_LAUNCH: ack_cnt <= '0;
        ST_WAIT_ACK:
          if (!cu_busy) begin
            if (ack_timeout) err_q <= 1'b1;
            else             ack_cnt <= ack_cnt + 1'b1;
          end
        ST_WAIT_DONE:
          if (!cu_busy) begin
            res_q <= cu_result;
            err_q <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           done_count <= '0;
    else if (state == ST_RESP && rsp_take) done_count <= done_count + 16'd1;
  end

endmodule

// File: tb/tb_cbrt_arbiter.sv
// Self-checking bench for cbrt_arbiter with a behavioural cbrt unit.
module tb_cbrt_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cu_start;
  logic [7:0]  cu_x;
  logic        cu_busy;
  logic [2:0]  cu_result;
  logic [1:0]  grant_id;
  logic        active;
  logic [15:0] done_count;

  cbrt_arbiter_if #(.N_REQ(N), .W_X(8), .W_R(3)) bus ();

  cbrt_arbiter #(.N_REQ(N), .W_X(8), .W_R(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cu_start   (cu_start),
    .cu_x       (cu_x),
    .cu_busy    (cu_busy),
    .cu_result  (cu_result),
    .grant_id   (grant_id),
    .active     (active),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // cube-root unit model and its knobs
  int cu_cnt;
  int lat_min = 0;
  int lat_max = 3;
  bit cu_dead = 1'b0;

  function automatic int icbrt(int v);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cu_busy   <= 1'b0;
      cu_result <= '0;
      cu_cnt    <= 0;
    end else if (cu_start && !cu_dead) begin
      cu_busy   <= 1'b1;
      cu_cnt    <= $urandom_range(lat_max, lat_min);
      cu_result <= 3'(icbrt(int'(cu_x)));
    end else if (cu_busy) begin
      if (cu_cnt == 0) cu_busy <= 1'b0;
      else             cu_cnt  <= cu_cnt - 1;
    end
  end

  // reference model state
  int m_last;
  bit m_inflight;
  int m_done;
  int cur_id, cur_res, g_cyc, cyc, granted;
  logic [7:0] q_x;
  bit rsp_seen;
  int grant_log[$];
  int serve_id[$];
  int serve_res[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic reset_model();
    m_last     = N - 1;
    m_inflight = 1'b0;
    m_done     = 0;
    rsp_seen   = 1'b0;
  endtask

  // Check one cycle at (negedge + 1) and advance to the next negedge.
  task automatic tick();
    int e;
    bit busy0;
    logic [N-1:0] exp_gnt, exp_rsp;
    #1;
    busy0 = m_inflight;
    check("done_count", done_count, 32'(16'(m_done)));
    check("active", active, busy0);
    check("cu_start", cu_start, busy0 && (cyc == g_cyc + 1));
    if (busy0 && cyc == g_cyc + 1) check("cu_x", cu_x, q_x);
    if (busy0) check("grant_id", grant_id, cur_id);
    e = model_pick(bus.req_valid, m_last);
    exp_gnt = '0;
    if (!busy0 && e >= 0) exp_gnt[e] = 1'b1;
    check("req_ready", bus.req_ready, exp_gnt);
    if (bus.rsp_valid != 0 || rsp_seen) begin
      if (!busy0) check("rsp_spurious", bus.rsp_valid, 0);
      else begin
        exp_rsp = '0;
        exp_rsp[cur_id] = 1'b1;
        check("rsp_valid", bus.rsp_valid, exp_rsp);
        check("rsp_err", bus.rsp_err, cu_dead);
        if (!cu_dead) check("rsp_result", bus.rsp_result, cur_res);
        if (cu_dead && !rsp_seen) check("err_by_T5", (cyc - g_cyc) <= 5, 1);
        rsp_seen = 1'b1;
        if (bus.rsp_ready[cur_id]) begin
          m_inflight = 1'b0;
          m_done++;
          rsp_seen = 1'b0;
          serve_id.push_back(cur_id);
          serve_res.push_back(int'(bus.rsp_result));
        end
      end
    end
    granted = -1;
    if (!busy0 && e >= 0) begin
      granted    = e;
      m_last     = e;
      m_inflight = 1'b1;
      g_cyc      = cyc;
      cur_id     = e;
      q_x        = bus.req_x[e*8 +: 8];
      cur_res    = icbrt(int'(q_x));
      rsp_seen   = 1'b0;
      grant_log.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  // mode 0: hold requests; 1: granted requester drops; 2: random traffic
  task automatic run(int ncyc, int mode);
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (granted >= 0 && mode != 0) bus.req_valid[granted] = 1'b0;
      if (mode == 2) begin
        for (int i = 0; i < N; i++) begin
          if (!bus.req_valid[i] && $urandom_range(2, 0) == 0) begin
            bus.req_valid[i]     = 1'b1;
            bus.req_x[i*8 +: 8]  = 8'($urandom);
          end else if (bus.req_valid[i] && $urandom_range(15, 0) == 0)
            bus.req_valid[i] = 1'b0;
        end
        bus.rsp_ready = N'($urandom);
      end
    end
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    for (int c = 0; c < 100 && m_inflight; c++) run(1, 1);
    check("drain_timeout", m_inflight, 0);
    run(1, 1);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_cu_start", cu_start, 0);
    check("rst_cu_x", cu_x, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_active", active, 0);
    check("rst_done_count", done_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  initial begin
    int exp_res[4] = '{2, 5, 6, 0};
    int n_before;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.rsp_ready = '0;
    cyc = 0;
    g_cyc = -10;
    reset_model();
    @(negedge clk);

    // reset state
    do_reset();

    // single request x=27
    bus.rsp_ready = '1;
    bus.req_x[7:0] = 8'd27;
    bus.req_valid  = 4'b0001;
    for (int c = 0; c < 60 && serve_id.size() < 1; c++) run(1, 1);
    run(1, 1);
    check("single_count", serve_id.size(), 1);
    if (serve_id.size() >= 1) begin
      check("single_id", serve_id[0], 0);
      check("single_result", serve_res[0], 3);
    end
    check("single_done", done_count, 1);

    // contention from a fresh reset: x = 8,125,216,0
    do_reset();
    serve_id.delete(); serve_res.delete(); grant_log.delete();
    bus.req_x     = {8'd0, 8'd216, 8'd125, 8'd8};
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    for (int c = 0; c < 300 && serve_id.size() < 4; c++) run(1, 1);
    run(1, 1);
    check("contention_count", serve_id.size(), 4);
    for (int i = 0; i < 4 && i < serve_id.size(); i++) begin
      check("contention_id", serve_id[i], i);
      check("contention_result", serve_res[i], exp_res[i]);
    end
    check("contention_done", done_count, 4);

    // fairness: all held valid for 8 grants
    grant_log.delete();
    bus.req_valid = '1;
    for (int c = 0; c < 400 && grant_log.size() < 8; c++) run(1, 0);
    check("fair_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check("fair_order", grant_log[i], i % 4);
    drain();

    // backpressure on requester 1 with everyone else pending
    bus.req_valid = '1;
    bus.rsp_ready = 4'b1101;
    for (int c = 0; c < 100 && !bus.rsp_valid[1]; c++) run(1, 0);
    check("bp_reached", bus.rsp_valid, 4'b0010);
    n_before = grant_log.size();
    run(20, 0);
    check("bp_hold_valid", bus.rsp_valid, 4'b0010);
    check("bp_no_grant", grant_log.size(), n_before);
    drain();

    // random traffic with random backpressure
    serve_id.delete(); serve_res.delete();
    run(800, 2);
    drain();
    check("random_progress", serve_id.size() > 20, 1);

    // missing acknowledge
    cu_dead = 1'b1;
    n_before = serve_id.size();
    bus.req_x[23:16] = 8'd64;
    bus.req_valid    = 4'b0100;
    for (int c = 0; c < 40 && serve_id.size() == n_before; c++) run(1, 1);
    check("noack_served", serve_id.size(), n_before + 1);
    run(2, 1);
    cu_dead = 1'b0;

    // reset during WAIT_DONE, then x=255
    lat_min = 10;
    lat_max = 10;
    bus.req_x[7:0] = 8'd100;
    bus.req_valid  = 4'b0001;
    for (int c = 0; c < 50 && !(m_inflight && cu_busy); c++) run(1, 1);
    run(1, 1);
    check("midop_active", active, 1);
    do_reset();
    lat_min = 0;
    lat_max = 3;
    serve_id.delete(); serve_res.delete();
    bus.req_x[23:16] = 8'd255;
    bus.req_valid    = 4'b0100;
    for (int c = 0; c < 60 && serve_id.size() < 1; c++) run(1, 1);
    run(1, 1);
    check("after_rst_count", serve_id.size(), 1);
    if (serve_id.size() >= 1) begin
      check("after_rst_id", serve_id[0], 2);
      check("after_rst_result", serve_res[0], 6);
    end
    check("after_rst_done", done_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
